// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the LEGv8 fetch stage.
// Holds the fetch address, advances it on accepted fetches, applies branch redirects,
// exception entry/return, and inserts BUBBLE idle fetch cycles after any control-flow change.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0100,
  parameter int unsigned      BUBBLE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret_valid,
  output logic [WIDTH-1:0] elr,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] ExcVec    = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] InstrInc  = WIDTH'(INSTR_BYTES);
  // Ones in the instruction-offset bits; the complement clears them.
  localparam logic [WIDTH-1:0] OffMask   = WIDTH'(INSTR_BYTES - 1);
  localparam logic [2:0]       BubLoad   = (BUBBLE > 0) ? 3'(BUBBLE - 1) : 3'd0;
  localparam bit               HasBubble = (BUBBLE > 0);

  typedef enum logic [1:0] {
    StStart,
    StRun,
    StBub
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] elr_q, elr_d;
  logic             misalign_q, misalign_d;

  logic             redir_evt;
  logic             tgt_misaligned;
  logic             accept;

  assign fetch_valid    = (state_q == StRun);
  assign pc             = pc_q;
  assign pc_next_seq    = pc_q + InstrInc;
  assign elr            = elr_q;
  assign misalign       = misalign_q;

  assign redir_evt      = exc_valid | eret_valid | redirect_valid;
  assign tgt_misaligned = (redirect_target & OffMask) != '0;
  assign accept         = fetch_valid & fetch_ready;

  // Next pc/elr/misalign by fixed priority: reset, exception, eret, redirect, sequential fetch.
  always_comb begin
    pc_d       = pc_q;
    elr_d      = elr_q;
    misalign_d = 1'b0;
    if (reset) begin
      pc_d  = RESET_VECTOR;
      elr_d = '0;
    end else if (exc_valid) begin
      pc_d  = ExcVec;
      elr_d = exc_pc;
    end else if (eret_valid) begin
      // Force alignment so a corrupted elr cannot trap again on return.
      pc_d = elr_q & ~OffMask;
    end else if (redirect_valid && tgt_misaligned) begin
      pc_d       = ExcVec;
      elr_d      = redirect_target;
      misalign_d = 1'b1;
    end else if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (accept) begin
      pc_d = pc_next_seq;
    end
  end

  // Fetch-valid state machine: any redirect-class event (re)starts the bubble count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (reset) begin
      state_d = StStart;
      cnt_d   = 3'd0;
    end else if (redir_evt) begin
      if (HasBubble) begin
        state_d = StBub;
        cnt_d   = BubLoad;
      end else begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    end else begin
      unique case (state_q)
        StStart: state_d = StRun;
        StRun:   state_d = StRun;
        StBub: begin
          if (cnt_q == 3'd0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = StStart;
      endcase
    end
  end

  // State registers; reset is applied through the next-state logic.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    pc_q       <= pc_d;
    elr_q      <= elr_d;
    misalign_q <= misalign_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts the post-edge outputs,
// a monitor compares them every cycle; a second narrow instance covers wrap and zero-bubble.
module tb_pc_sequencer;

  localparam int unsigned IB  = 4;
  localparam int unsigned BUB = 2;
  localparam logic [31:0] RV  = 32'h0;
  localparam logic [31:0] EXC = 32'h0000_0100;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=32, BUBBLE=2.
  logic        reset, fetch_ready, redirect_valid, exc_valid, eret_valid;
  logic [31:0] redirect_target, exc_pc;
  logic        fetch_valid, misalign;
  logic [31:0] pc, pc_next_seq, elr;

  pc_sequencer #(
    .WIDTH(32), .INSTR_BYTES(IB), .RESET_VECTOR(RV), .EXC_VECTOR(EXC), .BUBBLE(BUB)
  ) u_dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc(pc), .pc_next_seq(pc_next_seq), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .eret_valid(eret_valid), .elr(elr), .misalign(misalign)
  );

  // Narrow instance: WIDTH=8, BUBBLE=0, exception vector truncates to 0x00.
  logic       s_reset = 1'b1, s_ready = 1'b0, s_rv = 1'b0, s_ev = 1'b0, s_er = 1'b0;
  logic [7:0] s_rt = 8'h0, s_ep = 8'h0;
  logic       s_fv, s_mis;
  logic [7:0] s_pc, s_pcn, s_elr;

  pc_sequencer #(
    .WIDTH(8), .INSTR_BYTES(4), .RESET_VECTOR(8'hF0), .EXC_VECTOR(32'h0000_0100), .BUBBLE(0)
  ) u_w8 (
    .clk(clk), .reset(s_reset), .fetch_valid(s_fv), .fetch_ready(s_ready),
    .pc(s_pc), .pc_next_seq(s_pcn), .redirect_valid(s_rv), .redirect_target(s_rt),
    .exc_valid(s_ev), .exc_pc(s_ep), .eret_valid(s_er), .elr(s_elr), .misalign(s_mis)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tag;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] elr;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: started = left START, bub_left = fetch-idle cycles still owed.
  logic        m_started = 1'b0;
  int unsigned m_bub     = 0;
  logic [31:0] m_pc = '0, m_elr = '0;
  logic        m_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_apply(input logic rst, input logic rdy, input logic rv,
                             input logic [31:0] rt, input logic ev, input logic [31:0] ep,
                             input logic er);
    logic fv;
    fv = m_started && (m_bub == 0);
    if (rst) begin
      m_pc = RV; m_elr = '0; m_mis = 1'b0; m_started = 1'b0; m_bub = 0;
    end else begin
      m_mis = 1'b0;
      if (ev) begin
        m_pc = EXC; m_elr = ep;
      end else if (er) begin
        m_pc = m_elr - (m_elr % IB);
      end else if (rv && (rt % IB) != 0) begin
        m_pc = EXC; m_elr = rt; m_mis = 1'b1;
      end else if (rv) begin
        m_pc = rt;
      end else if (fv && rdy) begin
        m_pc = m_pc + IB;
      end
      if (ev || er || rv) m_bub = BUB;
      else if (m_bub > 0) m_bub--;
      m_started = 1'b1;
    end
  endtask

  // Apply one cycle of stimulus, record the prediction, then move to just after the edge.
  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rt,
                      input logic ev, input logic [31:0] ep, input logic er);
    exp_t e;
    reset = rst; fetch_ready = rdy; redirect_valid = rv; redirect_target = rt;
    exc_valid = ev; exc_pc = ep; eret_valid = er;
    model_apply(rst, rdy, rv, rt, ev, ep, er);
    e.tag = cyc + 1; e.fv = m_started && (m_bub == 0); e.pc = m_pc; e.elr = m_elr; e.mis = m_mis;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compare every cycle whose prediction is due; late entries count as failures.
  always begin : mon
    exp_t e;
    @(posedge clk); #3;
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      e = exp_q.pop_front();
      check("stale_expectation", 32'(e.tag), 32'(cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e = exp_q.pop_front();
      check("sb_fetch_valid", 32'(fetch_valid), 32'(e.fv));
      check("sb_pc", pc, e.pc);
      check("sb_pc_next_seq", pc_next_seq, e.pc + IB);
      check("sb_elr", elr, e.elr);
      check("sb_misalign", 32'(misalign), 32'(e.mis));
    end
  end

  initial begin
    reset = 1'b1; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_valid = 1'b0; exc_pc = '0; eret_valid = 1'b0;
    @(posedge clk); #1;

    // Reset and sequential fetch.
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    idle(1, 1'b1);
    check("first_fv", 32'(fetch_valid), 32'd1);
    idle(2, 1'b1);
    check("seq_pc8", pc, 32'h8);
    // Stall at pc=8.
    idle(3, 1'b0);
    check("stall_pc", pc, 32'h8);
    check("stall_fv", 32'(fetch_valid), 32'd1);
    idle(1, 1'b1);
    check("after_stall", pc, 32'hC);
    idle(1, 1'b1);
    // Redirect to 0x40 at pc=0x10 with two bubbles.
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 0, 1'b0);
    check("redir_pc", pc, 32'h40);
    check("redir_bub1", 32'(fetch_valid), 32'd0);
    idle(1, 1'b1);
    check("redir_bub2", 32'(fetch_valid), 32'd0);
    idle(1, 1'b1);
    check("redir_valid", 32'(fetch_valid), 32'd1);
    idle(1, 1'b1);
    check("redir_next", pc, 32'h44);
    // Exception beats a coincident redirect, then eret.
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h20, 1'b0);
    check("exc_pc", pc, EXC);
    check("exc_elr", elr, 32'h20);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    check("eret_pc", pc, 32'h20);
    idle(3, 1'b1);
    // Misaligned redirect becomes an exception.
    step(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 0, 1'b0);
    check("mis_pc", pc, EXC);
    check("mis_elr", elr, 32'h42);
    check("mis_pulse", 32'(misalign), 32'd1);
    idle(1, 1'b1);
    check("mis_clear", 32'(misalign), 32'd0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    check("mis_eret_pc", pc, 32'h40);
    // Reset during a bubble.
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check("midbub_rst_pc", pc, RV);
    check("midbub_rst_fv", 32'(fetch_valid), 32'd0);
    idle(1, 1'b1);
    check("midbub_rst_rise", 32'(fetch_valid), 32'd1);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] t;
      logic rst, rv, ev, er;
      r   = $urandom_range(0, 99);
      rst = (r < 1);
      ev  = (r >= 1 && r < 5);
      er  = (r >= 4 && r < 9);
      rv  = (r >= 3 && r < 14);
      t   = $urandom;
      if ($urandom_range(0, 1) == 0) t = t & ~32'(IB - 1);
      step(rst, ($urandom_range(0, 3) != 0), rv, t, ev, $urandom, er);
    end
    idle(2, 1'b1);
    reset = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
    @(posedge clk); #4;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Narrow instance: wrap, zero-bubble redirect, truncated exception vector.
    #2;
    s_ready = 1'b1;
    @(posedge clk); #1;
    check("w8_rst_pc", 32'(s_pc), 32'hF0);
    check("w8_rst_fv", 32'(s_fv), 32'd0);
    s_reset = 1'b0;
    @(posedge clk); #1;
    check("w8_start_pc", 32'(s_pc), 32'hF0);
    check("w8_start_fv", 32'(s_fv), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("w8_pc_fc", 32'(s_pc), 32'hFC);
    check("w8_next_wrap", 32'(s_pcn), 32'h00);
    @(posedge clk); #1;
    check("w8_wrap", 32'(s_pc), 32'h00);
    s_rv = 1'b1; s_rt = 8'h30;
    @(posedge clk); #1;
    s_rv = 1'b0;
    check("w8_nobub_pc", 32'(s_pc), 32'h30);
    check("w8_nobub_fv", 32'(s_fv), 32'd1);
    s_ev = 1'b1; s_ep = 8'h55;
    @(posedge clk); #1;
    s_ev = 1'b0;
    check("w8_exc_pc", 32'(s_pc), 32'h00);
    check("w8_exc_elr", 32'(s_elr), 32'h55);
    s_er = 1'b1;
    @(posedge clk); #1;
    s_er = 1'b0;
    check("w8_eret_pc", 32'(s_pc), 32'h54);
    check("w8_mis", 32'(s_mis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the LEGv8 fetch stage. It holds the fetch address and advances it by one instruction per accepted fetch. It applies branch redirects, exception entry and exception return, and inserts a configurable number of fetch bubbles after every control-flow change. It sits between the branch/exception logic in execute and the instruction memory port.

## Interface
- WIDTH, 32: address width in bits (≥ 8).
- INSTR_BYTES, 4: instruction size in bytes; power of two, ≥ 2.
- RESET_VECTOR, 0: PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0100: PC value loaded on exception entry; truncated to WIDTH.
- BUBBLE, 1: fetch_valid-low cycles after any redirect-class event; range 0..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- fetch_valid  out  1  pc is a valid fetch request.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- pc  out  WIDTH  current fetch address.
- pc_next_seq  out  WIDTH  combinational pc + INSTR_BYTES, mod 2^WIDTH; feeds the BL link path.
- redirect_valid  in  1  taken branch resolved; single-cycle pulse.
- redirect_target  in  WIDTH  branch target.
- exc_valid  in  1  exception raised; single-cycle pulse.
- exc_pc  in  WIDTH  address of the faulting instruction.
- eret_valid  in  1  exception return; single-cycle pulse.
- elr  out  WIDTH  exception link register.
- misalign  out  1  one-cycle pulse when a misaligned redirect was converted to an exception.

## Operation
- Let A = log2(INSTR_BYTES). A target is misaligned when target[A-1:0] != 0.
- Priority is evaluated each cycle, highest first. Exactly one action is taken:
  1. reset: pc <= RESET_VECTOR, elr <= 0, misalign <= 0, state <= START.
  2. exc_valid: pc <= EXC_VECTOR, elr <= exc_pc. Any coincident redirect or eret is dropped.
  3. eret_valid: pc <= {elr[WIDTH-1:A], A'b0}. The low bits are forced to zero so a misaligned elr cannot cause a loop.
  4. redirect_valid with a misaligned target: pc <= EXC_VECTOR, elr <= redirect_target, misalign <= 1 for the next cycle only.
  5. redirect_valid with an aligned target: pc <= redirect_target.
  6. fetch_valid && fetch_ready: pc <= pc_next_seq. Wrap from 2^WIDTH - INSTR_BYTES to 0 is silent.
  7. Otherwise: pc holds.
- Actions 2–5 are redirect-class events. Each one restarts the bubble sequence, even if it arrives during a bubble.
- Redirect-class events are taken regardless of fetch_valid or fetch_ready. An outstanding unaccepted fetch is abandoned.
- State machine (fetch_valid = 1 only in RUN):
  - START: entered on reset. Goes to RUN on the first edge with reset low. fetch_valid = 0.
  - RUN: on a redirect-class event, go to BUB with cnt <= BUBBLE-1 if BUBBLE > 0; otherwise stay in RUN.
  - BUB: cnt decrements each cycle; go to RUN when cnt == 0. A new redirect-class event reloads cnt <= BUBBLE-1.
- misalign is 0 in every cycle not directly following action 4.

## Timing
- Reset values: pc = RESET_VECTOR, fetch_valid = 0, elr = 0, misalign = 0.
- fetch_valid rises one cycle after reset deasserts.
- Handshake:
  - A fetch completes in a cycle with fetch_valid = 1 and fetch_ready = 1; pc advances at that edge.
  - While fetch_ready = 0, pc and fetch_valid hold stable.
- Redirect latency: the new pc is visible one cycle after the event.
  - fetch_valid is low for exactly BUBBLE cycles, starting in that cycle.
  - The new pc is presented valid in cycle BUBBLE+1 after the event.
- Reset asserted mid-bubble or mid-stall: the next edge gives pc = RESET_VECTOR, state START, elr = 0.
- pc_next_seq is combinational from pc only; it has no path from any input.

## Test plan
- Reset and sequential fetch (WIDTH=32, RESET_VECTOR=0, fetch_ready=1): fetch_valid=0 in the first cycle after reset, then pc = 0, 4, 8, 12 on consecutive cycles.
- Stall: at pc=8, hold fetch_ready=0 for 3 cycles -> pc stays 8 and fetch_valid stays 1; release -> next pc = 12.
- Redirect with bubble (BUBBLE=2): redirect to 0x40 at pc=0x10 -> pc=0x40, fetch_valid low for 2 cycles, then 0x40 accepted, then 0x44. Repeat with BUBBLE=0 -> no low cycle.
- Exception over redirect: exc_valid (exc_pc=0x20) together with redirect_valid (0x80) -> pc=0x100, elr=0x20. A later eret_valid -> pc=0x20.
- Misaligned redirect to 0x42 -> pc=0x100, elr=0x42, misalign high for one cycle. A later eret -> pc=0x40.
- Wrap and mid-bubble reset (WIDTH=8): pc 0xFC -> 0x00. Assert reset during a bubble -> pc=RESET_VECTOR and fetch_valid=0, rising one cycle after release.
